// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg - shared definitions for the EX-stage multiply/divide unit.
//   MDOP_W / mdop_t     : width and type of the one-hot operation vector
//   MDOP_MULT..MDOP_MTLO: bit positions inside the operation vector
//   mdu_state_e         : controller state encoding
//   neg32               : two's-complement negation helper
package mdu_ctrl_pkg;

  localparam int MDOP_W       = 8;
  localparam int DIV_ITER_DEF = 32;

  localparam int MDOP_MULT  = 0;
  localparam int MDOP_MULTU = 1;
  localparam int MDOP_DIV   = 2;
  localparam int MDOP_DIVU  = 3;
  localparam int MDOP_MFHI  = 4;
  localparam int MDOP_MFLO  = 5;
  localparam int MDOP_MTHI  = 6;
  localparam int MDOP_MTLO  = 7;

  typedef logic [MDOP_W-1:0] mdop_t;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return (~x) + 32'd1;
  endfunction

endpackage

// File: rtl/mdu_div32.sv
// mdu_div32 - iterative unsigned restoring divider, one quotient bit per cycle.
//   clk, rst    : clock, synchronous active-high reset
//   start_i     : load operands and begin a new division
//   flush_i     : abandon the division in progress
//   dividend_i  : 32-bit unsigned dividend
//   divisor_i   : 32-bit unsigned divisor (0 yields quotient all-ones, remainder = dividend)
//   done_o      : high during the cycle whose closing edge performs the final step
//   quot_o      : quotient (stable once the division has completed)
//   rem_o       : remainder (stable once the division has completed)
module mdu_div32
  import mdu_ctrl_pkg::*;
#(
  parameter int DIV_ITER = DIV_ITER_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        flush_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  localparam int CNT_W = $clog2(DIV_ITER + 1);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      quot_q;
  logic [31:0]      rem_q;
  logic [31:0]      dvs_q;

  logic [32:0]      shift_s;
  logic [31:0]      sub_s;
  logic             ge_s;

  // One restoring step: shift the next dividend bit in and try to subtract.
  // The true difference is below the divisor whenever ge_s holds, so 32 bits suffice.
  always_comb begin
    shift_s = {rem_q, quot_q[31]};
    sub_s   = shift_s[31:0] - dvs_q;
    ge_s    = (shift_s >= {1'b0, dvs_q});
  end

  assign done_o = busy_q && (cnt_q == CNT_W'(DIV_ITER - 1));
  assign quot_o = quot_q;
  assign rem_o  = rem_q;

  // Divider iteration state: load on start, step while busy, stop after the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quot_q <= 32'd0;
      rem_q  <= 32'd0;
      dvs_q  <= 32'd0;
    end else if (flush_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      quot_q <= dividend_i;
      rem_q  <= 32'd0;
      dvs_q  <= divisor_i;
    end else if (busy_q) begin
      rem_q  <= ge_s ? sub_s : shift_s[31:0];
      quot_q <= {quot_q[30:0], ge_s};
      cnt_q  <= cnt_q + CNT_W'(1);
      busy_q <= ~done_o;
    end else begin
      busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl - EX-stage multiply/divide controller owning the HI/LO registers.
//   clk, rst   : clock, synchronous active-high reset
//   flush_i    : pipeline flush, kills the in-flight operation and any HI/LO write
//   stall_i    : EX held by a downstream stage
//   mduop_i    : one-hot operation (mult, multu, div, divu, mfhi, mflo, mthi, mtlo)
//   opr1_i     : rs value (dividend / multiplicand / mthi-mtlo source)
//   opr2_i     : rt value (divisor / multiplier)
//   stallreq_o : EX must hold its instruction
//   result_o   : HI for mfhi, LO for mflo, otherwise 0
//   hi_o, lo_o : architectural HI / LO
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int DIV_ITER = DIV_ITER_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic [MDOP_W-1:0] mduop_i,
  input  logic [31:0]       opr1_i,
  input  logic [31:0]       opr2_i,
  output logic              stallreq_o,
  output logic [31:0]       result_o,
  output logic [31:0]       hi_o,
  output logic [31:0]       lo_o
);

  mdu_state_e  state_q, state_d;

  logic [31:0] hi_q, lo_q;
  logic [32:0] mul_a_q, mul_b_q;
  logic [63:0] prod_q;
  logic [63:0] prod_s;
  logic        is_div_q;
  logic        neg_quot_q, neg_rem_q;

  logic        is_mul_s, is_div_s, is_sdiv_s;
  logic        mul_start_s, div_start_s, commit_s;
  logic        mthi_we_s, mtlo_we_s;
  logic [31:0] dvd_mag_s, dvs_mag_s;
  logic        div_done_s;
  logic [31:0] quot_s, rem_s;
  logic [31:0] hi_res_s, lo_res_s;

  assign is_mul_s  = mduop_i[MDOP_MULT] | mduop_i[MDOP_MULTU];
  assign is_div_s  = mduop_i[MDOP_DIV]  | mduop_i[MDOP_DIVU];
  assign is_sdiv_s = mduop_i[MDOP_DIV];

  // Operand magnitudes for the unsigned divider core; 0x80000000 maps to itself, which is correct unsigned.
  always_comb begin
    if (is_sdiv_s && opr1_i[31]) begin
      dvd_mag_s = neg32(opr1_i);
    end else begin
      dvd_mag_s = opr1_i;
    end
    if (is_sdiv_s && opr2_i[31]) begin
      dvs_mag_s = neg32(opr2_i);
    end else begin
      dvs_mag_s = opr2_i;
    end
  end

  mdu_div32 #(
    .DIV_ITER (DIV_ITER)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start_s),
    .flush_i    (flush_i),
    .dividend_i (dvd_mag_s),
    .divisor_i  (dvs_mag_s),
    .done_o     (div_done_s),
    .quot_o     (quot_s),
    .rem_o      (rem_s)
  );

  // Operands are pre-extended to 33 bits, so one signed multiply serves both mult and multu.
  assign prod_s = 64'($signed(mul_a_q)) * 64'($signed(mul_b_q));

  // Final HI/LO values: product, or the divider result with the sign fix-up applied.
  always_comb begin
    if (is_div_q) begin
      lo_res_s = neg_quot_q ? neg32(quot_s) : quot_s;
      hi_res_s = neg_rem_q  ? neg32(rem_s)  : rem_s;
    end else begin
      lo_res_s = prod_q[31:0];
      hi_res_s = prod_q[63:32];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MDU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides everything, including a start in the same cycle.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = MDU_IDLE;
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (is_mul_s) begin
            state_d = MDU_MUL;
          end else if (is_div_s) begin
            state_d = MDU_DIV;
          end else begin
            state_d = MDU_IDLE;
          end
        end
        MDU_MUL: state_d = MDU_DONE;
        MDU_DIV: begin
          if (div_done_s) begin
            state_d = MDU_DONE;
          end else begin
            state_d = MDU_DIV;
          end
        end
        MDU_DONE: begin
          // A held DONE keeps the result and must not restart the same instruction.
          if (!stall_i) begin
            state_d = MDU_IDLE;
          end else begin
            state_d = MDU_DONE;
          end
        end
        default: state_d = MDU_IDLE;
      endcase
    end
  end

  // Output and strobe decode per state.
  always_comb begin
    stallreq_o  = 1'b0;
    mul_start_s = 1'b0;
    div_start_s = 1'b0;
    commit_s    = 1'b0;
    mthi_we_s   = 1'b0;
    mtlo_we_s   = 1'b0;
    case (state_q)
      MDU_IDLE: begin
        // A start under stall_i still proceeds: the instruction is held in EX anyway.
        mul_start_s = is_mul_s & ~flush_i;
        div_start_s = is_div_s & ~is_mul_s & ~flush_i;
        stallreq_o  = (is_mul_s | is_div_s) & ~flush_i;
        mthi_we_s   = mduop_i[MDOP_MTHI] & ~stall_i & ~flush_i;
        mtlo_we_s   = mduop_i[MDOP_MTLO] & ~stall_i & ~flush_i;
      end
      MDU_MUL:  stallreq_o = 1'b1;
      MDU_DIV:  stallreq_o = 1'b1;
      MDU_DONE: commit_s   = ~stall_i & ~flush_i;
      default:  stallreq_o = 1'b0;
    endcase
    if (mduop_i[MDOP_MFHI]) begin
      result_o = hi_q;
    end else if (mduop_i[MDOP_MFLO]) begin
      result_o = lo_q;
    end else begin
      result_o = 32'd0;
    end
  end

  // Operand capture, product register and HI/LO architectural state.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      mul_a_q    <= 33'd0;
      mul_b_q    <= 33'd0;
      prod_q     <= 64'd0;
      is_div_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      if (mul_start_s) begin
        mul_a_q  <= {mduop_i[MDOP_MULT] & opr1_i[31], opr1_i};
        mul_b_q  <= {mduop_i[MDOP_MULT] & opr2_i[31], opr2_i};
        is_div_q <= 1'b0;
      end else if (div_start_s) begin
        is_div_q   <= 1'b1;
        neg_quot_q <= is_sdiv_s & (opr1_i[31] ^ opr2_i[31]);
        neg_rem_q  <= is_sdiv_s & opr1_i[31];
      end else begin
        is_div_q <= is_div_q;
      end

      if (state_q == MDU_MUL) begin
        prod_q <= prod_s;
      end else begin
        prod_q <= prod_q;
      end

      if (commit_s) begin
        hi_q <= hi_res_s;
        lo_q <= lo_res_s;
      end else begin
        if (mthi_we_s) begin
          hi_q <= opr1_i;
        end else begin
          hi_q <= hi_q;
        end
        if (mtlo_we_s) begin
          lo_q <= opr1_i;
        end else begin
          lo_q <= lo_q;
        end
      end
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule
